// File: rtl/cpu_fetch.sv
// Instruction fetch: single-outstanding imem requests feeding a 2-entry queue.
// Define CPU_FETCH_MISALIGN_EN to add fetch_misalign and keep redirect_pc[1:0].
module cpu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        inst_valid
`ifdef CPU_FETCH_MISALIGN_EN
  ,
  output logic        fetch_misalign
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] pc0_q, pc0_d;
  logic [31:0] w0_q, w0_d;
  logic [31:0] pc1_q, pc1_d;
  logic [31:0] w1_q, w1_d;
  logic [1:0]  cnt_q, cnt_d;

  logic [31:0] tgt_pc;
  logic        halt;
  logic        issue;
  logic        push;
  logic        pop;

`ifdef CPU_FETCH_MISALIGN_EN
  logic mis_q, mis_d;

  always_comb begin
    tgt_pc = redirect_pc;
    halt   = mis_q;
    mis_d  = mis_q;
    if (redirect) mis_d = |redirect_pc[1:0];
  end
`else
  logic unused_pc_lo;

  assign unused_pc_lo = ^redirect_pc[1:0];

  always_comb begin
    tgt_pc = {redirect_pc[31:2], 2'b00};
    halt   = 1'b0;
  end
`endif

  always_comb begin
    issue = (state_q == S_IDLE) && (cnt_q != 2'd2)
          && !redirect && !halt;
    push  = (state_q == S_WAIT) && imem_rvalid && !redirect;
    pop   = (cnt_q != 2'd0) && !stall && !redirect;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    pc0_d      = pc0_q;
    w0_d       = w0_q;
    pc1_d      = pc1_q;
    w1_d       = w1_q;
    cnt_d      = cnt_q;

    if (redirect) begin
      // A request still in flight must have its response swallowed.
      fetch_pc_d = tgt_pc;
      cnt_d      = 2'd0;
      if (state_q != S_IDLE && !imem_rvalid) state_d = S_DROP;
      else                                   state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (issue) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = S_WAIT;
          end
        end
        S_WAIT, S_DROP: begin
          if (imem_rvalid) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      unique case (1'b1)
        push && !pop: begin
          if (cnt_q == 2'd0) begin
            pc0_d = req_pc_q;
            w0_d  = imem_rdata;
          end else begin
            pc1_d = req_pc_q;
            w1_d  = imem_rdata;
          end
          cnt_d = cnt_q + 2'd1;
        end
        pop && !push: begin
          pc0_d = pc1_q;
          w0_d  = w1_q;
          cnt_d = cnt_q - 2'd1;
        end
        push && pop: begin
          if (cnt_q == 2'd1) begin
            pc0_d = req_pc_q;
            w0_d  = imem_rdata;
          end else begin
            pc0_d = pc1_q;
            w0_d  = w1_q;
            pc1_d = req_pc_q;
            w1_d  = imem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'd0;
      pc0_q      <= 32'd0;
      w0_q       <= 32'd0;
      pc1_q      <= 32'd0;
      w1_q       <= 32'd0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      pc0_q      <= pc0_d;
      w0_q       <= w0_d;
      pc1_q      <= pc1_d;
      w1_q       <= w1_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef CPU_FETCH_MISALIGN_EN
  always_ff @(posedge clk) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= mis_d;
  end

  assign fetch_misalign = !reset && mis_q;
`endif

  always_comb begin
    imem_req    = !reset && issue;
    imem_addr   = imem_req ? fetch_pc_q : 32'd0;
    inst_valid  = !reset && (cnt_q != 2'd0);
    instruction = inst_valid ? w0_q : 32'd0;
    inst_pc     = inst_valid ? pc0_q : 32'd0;
  end

endmodule

// File: tb/tb_cpu_fetch.sv
// Randomized bench for cpu_fetch against a transaction-level queue model.
// Honors CPU_FETCH_MISALIGN_EN to connect and model fetch_misalign.
module tb_cpu_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int NCYC = 3000;
  localparam int RST2 = 900;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        inst_valid;
`ifdef CPU_FETCH_MISALIGN_EN
  logic        fetch_misalign;
`endif

  cpu_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .stall(stall),
    .instruction(instruction),
    .inst_pc(inst_pc),
    .inst_valid(inst_valid)
`ifdef CPU_FETCH_MISALIGN_EN
    ,
    .fetch_misalign(fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;

  // Model: delivered instructions queue, next fetch address, in-flight request.
  ent_t        q[$];
  logic [31:0] fpc;
  bit          pend;
  bit          stale;
  logic [31:0] paddr;
  int          pcnt;
  bit          mis;

  initial begin
    bit          ereq, vld, junk;
    int          lat;
    logic [31:0] tgt;
    q.delete();
    fpc   = RST_PC;
    pend  = 0;
    stale = 0;
    paddr = '0;
    pcnt  = 0;
    mis   = 0;
    reset = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    stall       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      reset = (cyc < 3) || (cyc == RST2) || (cyc == RST2 + 1);
      redirect    = 1'b0;
      redirect_pc = $urandom;
      stall       = 1'b0;
      lat         = 1;
      junk        = (cyc == 3) || (cyc == RST2 + 2);
      if (cyc >= 60 && cyc < 66) stall = 1'b1;
      if (cyc == 100) begin
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
      end
      if (cyc == 130) begin
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
      end
      if (cyc >= 160) begin
        stall = ($urandom_range(3) == 0);
        lat   = $urandom_range(3, 1);
        junk  = junk || ($urandom_range(4) == 0);
        if ($urandom_range(11) == 0) begin
          redirect = 1'b1;
          case ($urandom_range(4))
            0: tgt = 32'h0000_0100;
            1: tgt = 32'hFFFF_FFFC;
            2: tgt = 32'hFFFF_FFF8;
            3: tgt = 32'h0000_0102;
            default: tgt = $urandom;
          endcase
          redirect_pc = tgt;
        end
      end

      if (pend && pcnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memw(paddr);
      end else if (!pend && junk) begin
        imem_rvalid = 1'b1;
        imem_rdata  = $urandom;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end

      #1;
      vld  = !reset && (q.size() > 0);
      ereq = !reset && !pend && (q.size() < 2) && !redirect && !mis;
      chk("inst_valid", {31'd0, inst_valid}, {31'd0, vld});
      chk("inst_pc", inst_pc, vld ? q[0].pc : 32'd0);
      chk("instruction", instruction, vld ? q[0].w : 32'd0);
      chk("imem_req", {31'd0, imem_req}, {31'd0, ereq});
      if (ereq || reset)
        chk("imem_addr", imem_addr, reset ? 32'd0 : fpc);
`ifdef CPU_FETCH_MISALIGN_EN
      chk("fetch_misalign", {31'd0, fetch_misalign},
          {31'd0, !reset && mis});
`endif

      if (reset) begin
        q.delete();
        pend = 0;
        fpc  = RST_PC;
        mis  = 0;
      end else if (redirect) begin
        q.delete();
`ifdef CPU_FETCH_MISALIGN_EN
        fpc = redirect_pc;
        mis = (redirect_pc[1:0] != 2'b00);
`else
        fpc = {redirect_pc[31:2], 2'b00};
`endif
        if (pend) begin
          if (imem_rvalid) pend = 0;
          else begin
            stale = 1;
            pcnt--;
          end
        end
      end else begin
        if (vld && !stall) void'(q.pop_front());
        if (pend) begin
          if (imem_rvalid) begin
            if (!stale) q.push_back('{pc: paddr, w: imem_rdata});
            pend = 0;
          end else pcnt--;
        end else if (ereq) begin
          pend  = 1;
          stale = 0;
          paddr = fpc;
          pcnt  = lat - 1;
          fpc   = fpc + 32'd4;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port imem_req  output  1  one-cycle pulse requesting one instruction word.
REQ-005 SHALL have port imem_addr  output  32  word address for imem_req, valid only while imem_req=1.
REQ-006 SHALL have port imem_rvalid  input  1  memory response strobe, arriving at least one cycle after imem_req.
REQ-007 SHALL have port imem_rdata  input  32  instruction word, sampled when imem_rvalid=1.
REQ-008 SHALL have port redirect  input  1  taken branch, jal or jalr resolved downstream.
REQ-009 SHALL have port redirect_pc  input  32  new fetch target, sampled when redirect=1.
REQ-010 SHALL have port stall  input  1  decode/execute not accepting this cycle.
REQ-011 SHALL have port instruction  output  32  word presented to the control decoder.
REQ-012 SHALL have port inst_pc  output  32  address of instruction.
REQ-013 SHALL have port inst_valid  output  1  instruction/inst_pc valid.

Function
REQ-014 SHALL hold a 2-entry FIFO of {pc, word}; inst_valid = FIFO non-empty; instruction/inst_pc = head entry, 0 when empty.
REQ-015 SHALL pop the head when inst_valid=1 and stall=0 and redirect=0.
REQ-016 SHALL run FSM IDLE (nothing outstanding), WAIT (one request outstanding), DROP (outstanding response to be discarded); at most one request outstanding.
REQ-017 IDLE: SHALL assert imem_req with imem_addr=fetch_pc when FIFO count<2 and redirect=0, latch req_pc=fetch_pc, fetch_pc+=4 (mod 2^32, wraps FFFF_FFFC->0), go WAIT.
REQ-018 WAIT: on imem_rvalid=1 and redirect=0 SHALL push {req_pc, imem_rdata}, go IDLE; no new request issued in that cycle.
REQ-019 Redirect SHALL win over all simultaneous events: flush FIFO, fetch_pc<=redirect_pc, no request or push that cycle; next state IDLE from IDLE, DROP from WAIT without rvalid, IDLE from WAIT with rvalid (response dropped).
REQ-020 DROP: SHALL discard the response on imem_rvalid=1 and go IDLE; a further redirect in DROP only updates fetch_pc.
REQ-021 Redirect-to-use latency SHALL be: redirect at cycle N, imem_req at N+1, inst_valid the cycle after imem_rvalid.
REQ-022 FIFO SHALL never overflow (issue requires count<2) and pop on empty SHALL be a no-op.
REQ-023 imem_rvalid in IDLE SHALL be ignored.

Reset
REQ-024 While reset=1 SHALL drive imem_req=0, imem_addr=0, inst_valid=0, instruction=0, inst_pc=0; FSM=IDLE, FIFO empty, fetch_pc=RESET_PC.
REQ-025 Reset mid-request SHALL abandon the outstanding request; a late imem_rvalid after reset SHALL be ignored (state IDLE).
REQ-026 First imem_req SHALL occur in the first cycle after reset deasserts, addr=RESET_PC.

Configuration
REQ-027 Macro CPU_FETCH_MISALIGN_EN defined: SHALL add output fetch_misalign (1 bit, reset 0), set when redirect_pc[1:0]!=0 on redirect, which suppresses fetch until next redirect or reset; cleared by a aligned redirect.
REQ-028 Macro undefined: SHALL have no fetch_misalign port and SHALL force redirect_pc[1:0] to 2'b00.

Verification
REQ-029 Reset release, memory latency 1, stall=0 -> imem_addr sequence 0,4,8; inst_pc 0,4,8 with matching words, one instruction every 2 cycles.
REQ-030 stall=1 held 6 cycles -> FIFO fills to 2, imem_req stops, instruction/inst_pc stable; release -> entries in order, no loss or duplication.
REQ-031 redirect=1, redirect_pc=32'h100 while WAIT -> FIFO flushed, stale rvalid dropped, next imem_addr=32'h100, first inst_pc=32'h100.
REQ-032 redirect coincident with imem_rvalid and pop -> no push, no pop, inst_valid=0 next cycle, next imem_addr=redirect_pc.
REQ-033 redirect_pc=32'hFFFF_FFFC -> imem_addr FFFF_FFFC then 0000_0000.
REQ-034 With CPU_FETCH_MISALIGN_EN, redirect_pc=32'h102 -> fetch_misalign=1, no imem_req; redirect to 32'h200 -> fetch_misalign=0, imem_addr=32'h200.
